// File: rtl/cmp_check_pkg.sv
// cmp_check_pkg: shared types and the cyclic priority pick for the check scheduler
package cmp_check_pkg;
  localparam int IW = 4;
  localparam int MAXN = 16;
  typedef enum logic [1:0] {IDLE, EVAL, RESP} cc_state_e;
  typedef struct packed {
    logic found;
    logic [IW-1:0] idx;
  } pick_t;
  function automatic pick_t rr_pick(input logic [MAXN-1:0] req, input logic [IW-1:0] ptr, input int n);
    pick_t p;
    int j;
    p = '0;
    // scanned farthest-first so the candidate nearest to ptr is written last and wins
    for (int i = MAXN - 1; i >= 0; i--) begin
      j = (int'(ptr) + i) % n;
      if (i < n && req[j[IW-1:0]]) begin
        p.found = 1'b1;
        p.idx = IW'(j);
      end
    end
    return p;
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational cyclic priority pick starting at ptr
module rr_arbiter
  import cmp_check_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic            found,
  output logic [IW-1:0]   idx
);
  pick_t p;
  assign p = rr_pick(MAXN'(req), ptr, NREQ);
  assign found = p.found;
  assign idx = p.idx;
endmodule

// File: rtl/cmp_check_sched.sv
// cmp_check_sched: round-robin sharing of one equality checker with saturating pass/fail stats
module cmp_check_sched
  import cmp_check_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int DW   = 32,
  parameter int CNTW = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*DW-1:0]   op_a,
  input  logic [NREQ*DW-1:0]   op_b,
  input  logic                 clr_cnt,
  output logic [NREQ-1:0]      gnt,
  output logic [NREQ-1:0]      done,
  output logic                 pass,
  output logic                 busy,
  output logic [CNTW-1:0]      pass_cnt,
  output logic [CNTW-1:0]      fail_cnt
);
  cc_state_e state, state_n;
  logic [IW-1:0] idx, rr_ptr, pick;
  logic [NREQ-1:0] sel;
  logic found, hit, eq, eq_n;
  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req  (req),
    .ptr  (rr_ptr),
    .found(found),
    .idx  (pick)
  );
  assign sel = NREQ'(1) << idx;
  assign hit = |(req & sel);
  assign busy = state != IDLE;
  always_comb begin
    eq_n = 1'b0;
    for (int i = 0; i < NREQ; i++)
      if (sel[i]) eq_n = op_a[i*DW +: DW] == op_b[i*DW +: DW];
  end
  always_comb begin
    state_n = state;
    gnt = '0;
    done = '0;
    pass = 1'b0;
    case (state)
      IDLE: state_n = found ? EVAL : IDLE;
      EVAL: begin
        gnt = sel;
        state_n = hit ? RESP : IDLE;
      end
      RESP: begin
        done = sel;
        pass = eq;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      idx <= '0;
      rr_ptr <= '0;
      eq <= 1'b0;
      pass_cnt <= '0;
      fail_cnt <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && found) idx <= pick;
      if (state == EVAL) eq <= eq_n;
      if (state == RESP) rr_ptr <= idx == IW'(NREQ - 1) ? '0 : idx + IW'(1);
      if (clr_cnt) begin
        pass_cnt <= '0;
        fail_cnt <= '0;
      end else if (state == RESP) begin
        if (eq && !(&pass_cnt)) pass_cnt <= pass_cnt + CNTW'(1);
        if (!eq && !(&fail_cnt)) fail_cnt <= fail_cnt + CNTW'(1);
      end
    end
  end
endmodule

// File: tb/tb_cmp_check_sched.sv
// tb_cmp_check_sched: directed vector bench for the shared equality-check scheduler
module tb_cmp_check_sched;
  localparam int N = 4;
  localparam int DW = 32;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  logic [N-1:0] req, gnt, done;
  logic [N*DW-1:0] op_a, op_b;
  logic clr_cnt, pass, busy;
  logic [15:0] pass_cnt, fail_cnt;
  logic [N-1:0] s_req, s_gnt, s_done;
  logic [N*8-1:0] s_a, s_b;
  logic s_clr, s_pass, s_busy;
  logic [1:0] s_pc, s_fc;
  cmp_check_sched #(.NREQ(N), .DW(DW), .CNTW(16)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .op_a(op_a), .op_b(op_b), .clr_cnt(clr_cnt),
    .gnt(gnt), .done(done), .pass(pass), .busy(busy), .pass_cnt(pass_cnt), .fail_cnt(fail_cnt)
  );
  cmp_check_sched #(.NREQ(N), .DW(8), .CNTW(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .req(s_req), .op_a(s_a), .op_b(s_b), .clr_cnt(s_clr),
    .gnt(s_gnt), .done(s_done), .pass(s_pass), .busy(s_busy), .pass_cnt(s_pc), .fail_cnt(s_fc)
  );
  int checks = 0;
  int failures = 0;
  typedef struct {
    int r;
    logic [31:0] a;
    logic [31:0] b;
    logic p;
    int pc;
    int fc;
  } vec_t;
  vec_t v[5];
  int ord[5] = '{0, 1, 2, 3, 0};
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic set_op(input int r, input logic [31:0] a, input logic [31:0] b);
    op_a[r*DW +: DW] = a;
    op_b[r*DW +: DW] = b;
  endtask
  task automatic xact(input int r, input logic [31:0] a, input logic [31:0] b,
                      input logic p, input int pc, input int fc);
    set_op(r, a, b);
    req[r] = 1'b1;
    @(negedge clk);
    chk("gnt", gnt, 1 << r);
    chk("done_eval", done, 0);
    chk("busy_eval", busy, 1);
    @(negedge clk);
    chk("done", done, 1 << r);
    chk("pass", pass, p);
    chk("gnt_resp", gnt, 0);
    req[r] = 1'b0;
    @(negedge clk);
    chk("pass_cnt", pass_cnt, pc);
    chk("fail_cnt", fail_cnt, fc);
    chk("idle_busy", busy, 0);
  endtask
  initial begin
    req = '0;
    clr_cnt = 1'b0;
    s_req = '0;
    s_clr = 1'b0;
    for (int i = 0; i < N; i++) begin
      set_op(i, $urandom, $urandom);
      s_a[i*8 +: 8] = 8'($urandom);
      s_b[i*8 +: 8] = 8'($urandom);
    end
    #2;
    chk("rst_gnt", gnt, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_busy", busy, 0);
    chk("rst_pass_cnt", pass_cnt, 0);
    chk("rst_fail_cnt", fail_cnt, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_busy", busy, 0);
    v = '{'{1, 32'd5, 32'd5, 1'b1, 1, 0},
          '{2, 32'd5, 32'd6, 1'b0, 1, 1},
          '{0, 32'hffff_ffff, 32'hffff_ffff, 1'b1, 2, 1},
          '{3, 32'h8000_0000, 32'h0, 1'b0, 2, 2},
          '{3, 32'd1, 32'd1, 1'b1, 3, 2}};
    for (int i = 0; i < 5; i++) xact(v[i].r, v[i].a, v[i].b, v[i].p, v[i].pc, v[i].fc);
    // second requester arrives during EVAL and must wait for the current done
    set_op(2, 7, 7);
    req[2] = 1'b1;
    @(negedge clk);
    chk("blk_gnt", gnt, 4'b0100);
    set_op(1, 9, 9);
    req[1] = 1'b1;
    @(negedge clk);
    chk("blk_done", done, 4'b0100);
    chk("blk_gnt_resp", gnt, 0);
    chk("blk_pass", pass, 1);
    req[2] = 1'b0;
    @(negedge clk);
    chk("blk_idle_gnt", gnt, 0);
    chk("blk_idle_busy", busy, 0);
    chk("blk_pass_cnt", pass_cnt, 4);
    @(negedge clk);
    chk("blk_second_gnt", gnt, 4'b0010);
    @(negedge clk);
    chk("blk_second_done", done, 4'b0010);
    req[1] = 1'b0;
    @(negedge clk);
    chk("blk_second_cnt", pass_cnt, 5);
    // abort: req[3] dropped during EVAL
    req[3] = 1'b1;
    @(negedge clk);
    chk("abort_gnt", gnt, 4'b1000);
    req[3] = 1'b0;
    @(negedge clk);
    chk("abort_done", done, 0);
    chk("abort_busy", busy, 0);
    @(negedge clk);
    chk("abort_pass_cnt", pass_cnt, 5);
    chk("abort_fail_cnt", fail_cnt, 2);
    set_op(3, 3, 4);
    set_op(1, 2, 2);
    req[1] = 1'b1;
    req[3] = 1'b1;
    @(negedge clk);
    chk("abort_ptr_kept", gnt, 4'b1000);
    @(negedge clk);
    chk("abort_next_done", done, 4'b1000);
    chk("abort_next_pass", pass, 0);
    req = '0;
    @(negedge clk);
    chk("abort_next_fail", fail_cnt, 3);
    // async reset in RESP, with rr_ptr left non-zero beforehand
    xact(1, 32'h1234, 32'h1234, 1'b1, 6, 3);
    set_op(2, 1, 1);
    req[2] = 1'b1;
    @(negedge clk);
    chk("ar_gnt", gnt, 4'b0100);
    @(negedge clk);
    chk("ar_done_before", done, 4'b0100);
    #1 rst_n = 1'b0;
    #1;
    chk("ar_done", done, 0);
    chk("ar_pass", pass, 0);
    chk("ar_busy", busy, 0);
    chk("ar_pass_cnt", pass_cnt, 0);
    chk("ar_fail_cnt", fail_cnt, 0);
    req = '0;
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("ar_after_cnt", pass_cnt, 0);
    chk("ar_after_busy", busy, 0);
    // round-robin with all requesters asserted; first pick proves rr_ptr restarted at 0
    for (int i = 0; i < N; i++) set_op(i, 32'h55 + i, 32'h55 + i);
    req = '1;
    for (int c = 1; c <= 15; c++) begin
      @(negedge clk);
      chk("rr_gnt", gnt, (c % 3 == 1) ? (1 << ord[(c-1)/3]) : 0);
    end
    chk("rr_pass_cnt", pass_cnt, 5);
    req = '0;
    // saturation and clear on the 2-bit counter instance
    s_a[7:0] = 8'd1;
    s_b[7:0] = 8'd2;
    for (int k = 1; k <= 5; k++) begin
      s_req[0] = 1'b1;
      @(negedge clk);
      chk("sat_gnt", s_gnt, 1);
      @(negedge clk);
      chk("sat_done", s_done, 1);
      chk("sat_pass", s_pass, 0);
      if (k == 5) s_clr = 1'b1;
      s_req[0] = 1'b0;
      @(negedge clk);
      s_clr = 1'b0;
      chk("sat_fail_cnt", s_fc, k == 5 ? 0 : (k > 3 ? 3 : k));
    end
    chk("sat_pass_cnt", s_pc, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
